abuf_replay_fifo: RTL

ABUF_REPLAY_FIFO -- requirements
Module: abuf_replay_fifo

---
 rtl/abuf_replay_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/abuf_replay_fifo.sv
// abuf_replay_fifo
//   Packs narrow global-bus beats into wide activation-buffer words and stores
//   them in a replayable FIFO. Reads advance rptr; rewind returns rptr to the
//   base pointer bptr; release frees every word below rptr by moving bptr up.
//   A word stays readable any number of times until it is released.
//
// Parameters
//   GBUS_DATA   input beat width (bits)
//   ABUF_DATA   stored word width, integer multiple of GBUS_DATA
//   ABUF_DEPTH  word entries, power of two, >= 4
//   ALERT_DEPTH almost-full margin in words
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   wdata, wen                   input beat and beat valid
//   ren                          read request
//   rewind                       rptr <= bptr
//   rel                          bptr <= rptr (named rel: 'release' is a reserved word)
//   rdata, rvalid                read word (held) and one-cycle valid pulse
//   empty, full, almost_full     status, combinational from the pointers
//   count                        unreleased words (wptr - bptr)
//   err_ovf, err_udf             sticky overflow / underflow flags
//
// Build option
//   ABUF_ERR_EN  when defined, err_ovf/err_udf are sticky flags cleared only by
//                reset; when undefined both are tied to 0.
module abuf_replay_fifo #(
  parameter int GBUS_DATA   = 64,
  parameter int ABUF_DATA   = 256,
  parameter int ABUF_DEPTH  = 64,
  parameter int ALERT_DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [GBUS_DATA-1:0]          wdata,
  input  logic                          wen,
  input  logic                          ren,
  input  logic                          rewind,
  input  logic                          rel,
  output logic [ABUF_DATA-1:0]          rdata,
  output logic                          rvalid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic [$clog2(ABUF_DEPTH):0]   count,
  output logic                          err_ovf,
  output logic                          err_udf
);

  localparam int RATIO = ABUF_DATA / GBUS_DATA;
  localparam int AW    = $clog2(ABUF_DEPTH);
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(ABUF_DEPTH);
  localparam logic [AW:0]   ALERT_C   = (AW+1)'(ABUF_DEPTH - ALERT_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  logic [ABUF_DATA-1:0] mem [ABUF_DEPTH];

  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic [AW:0]          bptr;
  logic [BW-1:0]        bcnt;
  logic [ABUF_DATA-1:0] pack;
  logic [ABUF_DATA-1:0] pack_nxt;
  logic [ABUF_DATA-1:0] wword;
  logic                 wr_pend;
  logic                 do_write;
  logic                 do_read;

  // Status from registered pointers only
  assign count       = wptr - bptr;
  assign empty       = (rptr == wptr);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= ALERT_C);

  // Full is judged before any same-cycle release takes effect
  assign do_write = wr_pend & ~full;
  // Release and rewind both take priority over a read request
  assign do_read  = ren & ~empty & ~rel & ~rewind;

  always_comb begin
    pack_nxt = pack;
    pack_nxt[int'(bcnt)*GBUS_DATA +: GBUS_DATA] = wdata;
  end

  // Beat packing; a completed word is staged in wword so beats of the next
  // word can arrive while it is being written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt    <= '0;
      pack    <= '0;
      wword   <= '0;
      wr_pend <= 1'b0;
      wptr    <= '0;
    end else begin
      wr_pend <= 1'b0;
      if (wen) begin
        pack <= pack_nxt;
        if (bcnt == LAST_BEAT) begin
          bcnt    <= '0;
          wword   <= pack_nxt;
          wr_pend <= 1'b1;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
      if (do_write) begin
        wptr <= wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wptr[AW-1:0]] <= wword;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr   <= '0;
      bptr   <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= do_read;
      if (rel) begin
        bptr <= rptr;
      end else if (rewind) begin
        rptr <= bptr;
      end else if (do_read) begin
        rdata <= mem[rptr[AW-1:0]];
        rptr  <= rptr + 1'b1;
      end
    end
  end

`ifdef ABUF_ERR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (wr_pend & full) begin
        err_ovf <= 1'b1;
      end
      if (ren & empty & ~rel & ~rewind) begin
        err_udf <= 1'b1;
      end
    end
  end
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule
